// File: rtl/comma_word_aligner.sv
// rtl/comma_word_aligner.sv - K28.5 comma hunt and 10b word alignment for the CDR serial stream
module comma_word_aligner #(
  parameter int          LOCK_CNT   = 3,
  parameter int          UNLOCK_CNT = 4,
  parameter logic [9:0]  K_NEG      = 10'h17C,
  parameter logic [9:0]  K_POS      = 10'h283
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Din,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       k_flag,
  output logic       locked
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_LIM   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_LIM = 4'(UNLOCK_CNT);

  logic [9:0] sr;
  logic [3:0] cnt;
  state_t     state;
  state_t     state_n;
  logic [3:0] good;
  logic [3:0] good_n;
  logic [3:0] bad;
  logic [3:0] bad_n;
  logic [3:0] good_inc;
  logic [3:0] bad_inc;
  logic       comma_hit;
  logic       bnd;
  logic       take;

  // Comma decode works on the registered window, so a word is seen the edge after it completes.
  assign comma_hit = (sr == K_NEG) || (sr == K_POS);
  assign bnd       = (cnt == 4'd9);
  // Only HUNT may move the boundary; VERIFY and LOCKED just follow the counter.
  assign take      = bnd || ((state == HUNT) && comma_hit);
  assign locked    = (state == LOCKED);
  assign good_inc  = good + 4'd1;
  assign bad_inc   = bad + 4'd1;

  // Serial window: newest bit enters at the top, oldest (first received) sits in bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= 10'd0;
    end else begin
      sr <= {Din, sr[9:1]};
    end
  end

  // Boundary counter and word output register; a take restarts the 10-bit frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 4'd0;
      data_out   <= 10'd0;
      data_valid <= 1'b0;
      k_flag     <= 1'b0;
    end else if (take) begin
      cnt        <= 4'd0;
      data_out   <= sr;
      data_valid <= 1'b1;
      k_flag     <= comma_hit;
    end else begin
      cnt        <= cnt + 4'd1;
      data_valid <= 1'b0;
      k_flag     <= 1'b0;
    end
  end

  // Lock FSM state and its good/bad comma counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      good  <= 4'd0;
      bad   <= 4'd0;
    end else begin
      state <= state_n;
      good  <= good_n;
      bad   <= bad_n;
    end
  end

  // Next-state: count aligned commas up to lock, count misaligned commas down to loss.
  always_comb begin
    state_n = state;
    good_n  = good;
    bad_n   = bad;
    case (state)
      HUNT: begin
        if (comma_hit) begin
          good_n  = 4'd1;
          bad_n   = 4'd0;
          state_n = (LOCK_LIM == 4'd1) ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        if (comma_hit) begin
          if (bnd) begin
            good_n = good_inc;
            if (good_inc == LOCK_LIM) begin
              state_n = LOCKED;
              bad_n   = 4'd0;
            end
          end else begin
            // Misplaced comma: drop back and let HUNT realign on the next one.
            state_n = HUNT;
            good_n  = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (comma_hit) begin
          if (bnd) begin
            bad_n = 4'd0;
          end else begin
            bad_n = bad_inc;
            if (bad_inc == UNLOCK_LIM) begin
              state_n = HUNT;
              good_n  = 4'd0;
              bad_n   = 4'd0;
            end
          end
        end
      end
      default: begin
        state_n = HUNT;
        good_n  = 4'd0;
        bad_n   = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_comma_word_aligner.sv
// tb/tb_comma_word_aligner.sv - directed scoreboard bench for comma_word_aligner
module tb_comma_word_aligner;

  localparam logic [9:0] KN = 10'h17C;
  localparam logic [9:0] KP = 10'h283;

  typedef struct {
    int         e;
    logic [9:0] d;
    logic       k;
    logic       l;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       Din;
  logic [9:0] data_out;
  logic       data_valid;
  logic       k_flag;
  logic       locked;

  int         n_asserts;
  int         n_fail;
  int         edge_n;
  logic       last_bit;
  logic       slip;
  exp_t       sb[$];
  logic [9:0] dtab[8];

  comma_word_aligner dut (
    .clk        (clk),
    .rst        (rst),
    .Din        (Din),
    .data_out   (data_out),
    .data_valid (data_valid),
    .k_flag     (k_flag),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic sb_check();
    exp_t x;
    if (sb.size() > 0 && sb[0].e == edge_n) begin
      x = sb.pop_front();
      chk($sformatf("dv@%0d", edge_n), 10'(data_valid), 10'd1);
      chk($sformatf("data@%0d", edge_n), data_out, x.d);
      chk($sformatf("k@%0d", edge_n), 10'(k_flag), 10'(x.k));
      chk($sformatf("locked@%0d", edge_n), 10'(locked), 10'(x.l));
    end
  endtask

  task automatic send_bit(input logic b);
    Din = b;
    @(posedge clk);
    edge_n++;
    last_bit = b;
    #1;
    sb_check();
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) send_bit(~last_bit);
  endtask

  task automatic push(input int e, input logic [9:0] d, input logic k, input logic l);
    exp_t x;
    x.e = e;
    x.d = d;
    x.k = k;
    x.l = l;
    sb.push_back(x);
  endtask

  // Aligned words appear the edge after their last bit; with a 1-bit slip the
  // old boundary captures the previous bit plus the first nine bits of w.
  task automatic send_word(input logic [9:0] w, input logic chkf, input logic k_e, input logic l_e);
    if (chkf) begin
      if (slip) push(edge_n + 10, {w[8:0], last_bit}, 1'b0, l_e);
      else      push(edge_n + 11, w, k_e, l_e);
    end
    for (int i = 0; i < 10; i++) send_bit(w[i]);
  endtask

  function automatic logic [9:0] rand_d();
    return dtab[$urandom_range(0, 7)];
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_data"}, data_out, 10'd0);
    chk({tag, "_dv"}, 10'(data_valid), 10'd0);
    chk({tag, "_k"}, 10'(k_flag), 10'd0);
    chk({tag, "_locked"}, 10'(locked), 10'd0);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check_outputs_zero({tag, "_async"});
    @(posedge clk);
    #1;
    check_outputs_zero({tag, "_held"});
    @(negedge clk);
    rst      = 1'b0;
    edge_n   = 0;
    last_bit = 1'b0;
    slip     = 1'b0;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    edge_n    = 0;
    last_bit  = 1'b0;
    slip      = 1'b0;
    dtab      = '{10'h2AA, 10'h155, 10'h333, 10'h0CC, 10'h199, 10'h266, 10'h2D2, 10'h12D};
    rst       = 1'b1;
    Din       = 1'b0;

    // Power-on reset, a partial word, then reset again mid-word.
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("por");
    @(negedge clk);
    rst = 1'b0;
    fill(7);
    pulse_reset("mid_word_rst");

    // First boundary strobe lands on the tenth edge after release.
    push(10, 10'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      send_bit(1'b0);
      if (i < 10) chk($sformatf("no_dv_e%0d", i), 10'(data_valid), 10'd0);
    end

    // Acquire: three random bits then K28.5 RD-.
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    send_word(KN, 1'b1, 1'b1, 1'b0);

    // Lock on the third aligned comma.
    send_word(KP, 1'b1, 1'b1, 1'b0);
    send_word(rand_d(), 1'b1, 1'b0, 1'b0);
    send_word(KN, 1'b1, 1'b1, 1'b1);
    send_word(rand_d(), 1'b1, 1'b0, 1'b1);

    // Slip tolerance: three shifted commas keep lock and the old boundary.
    send_bit(~last_bit);
    slip = 1'b1;
    send_word(KN, 1'b1, 1'b0, 1'b1);
    send_word(rand_d(), 1'b1, 1'b0, 1'b1);
    send_word(KP, 1'b1, 1'b0, 1'b1);
    send_word(KN, 1'b1, 1'b0, 1'b1);
    fill(9);
    slip = 1'b0;
    chk("slip3_locked", 10'(locked), 10'd1);
    send_word(KN, 1'b1, 1'b1, 1'b1);
    send_bit(~last_bit);
    slip = 1'b1;
    send_word(KP, 1'b1, 1'b0, 1'b1);
    send_word(KN, 1'b1, 1'b0, 1'b1);
    send_word(KP, 1'b1, 1'b0, 1'b1);
    fill(9);
    slip = 1'b0;
    chk("slip6_locked", 10'(locked), 10'd1);

    // Loss: four consecutive misaligned commas after a clearing aligned one.
    send_word(KN, 1'b1, 1'b1, 1'b1);
    send_bit(~last_bit);
    slip = 1'b1;
    send_word(KP, 1'b1, 1'b0, 1'b1);
    send_word(KN, 1'b1, 1'b0, 1'b1);
    send_word(KP, 1'b1, 1'b0, 1'b1);
    send_word(KN, 1'b1, 1'b0, 1'b1);
    send_bit(~last_bit);
    chk("loss_locked", 10'(locked), 10'd0);
    slip = 1'b0;

    // Realign in HUNT, then relock.
    send_word(KN, 1'b1, 1'b1, 1'b0);
    send_word(rand_d(), 1'b1, 1'b0, 1'b0);
    send_word(KP, 1'b1, 1'b1, 1'b0);
    send_word(KN, 1'b1, 1'b1, 1'b1);
    send_bit(~last_bit);
    chk("pre_rst_drained", 10'(sb.size()), 10'd0);
    pulse_reset("locked_rst");

    // VERIFY abort: comma five bits off the boundary returns to HUNT without realigning.
    send_word(KN, 1'b1, 1'b1, 1'b0);
    fill(5);
    send_word(KP, 1'b0, 1'b0, 1'b0);
    send_bit(~last_bit);
    chk("abort_no_dv", 10'(data_valid), 10'd0);
    chk("abort_locked", 10'(locked), 10'd0);
    send_word(KN, 1'b1, 1'b1, 1'b0);
    send_word(rand_d(), 1'b1, 1'b0, 1'b0);
    send_word(KP, 1'b1, 1'b1, 1'b0);
    send_word(KN, 1'b1, 1'b1, 1'b1);
    fill(2);

    chk("sb_drained", 10'(sb.size()), 10'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
